pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core. It turns stall requests from the decode stage and multi-cycle requests from the execute stage into a per-stage stall vector.
- Owns a countdown FSM that holds EX for multi-cycle ops (mult/div class) and signals the release cycle.
- Handles flush/redirect requests from MEM and keeps a saturating stall-cycle performance counter.
- Sits beside the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, which all consume stall_o.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_if.sv | 32 +++
 rtl/pipe_ctrl_sat_counter.sv | 20 ++
 rtl/pipe_ctrl.sv | 104 ++++++++++
 tb/tb_pipe_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer.
// Stall vectors, FSM states and default widths.
package pipe_ctrl_pkg;

    localparam int MC_W_DEF   = 6;
    localparam int PERF_W_DEF = 32;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic {
        PC_RUN     = 1'b0,
        PC_MC_WAIT = 1'b1
    } pc_state_t;

    function automatic logic [5:0] id_stall(input logic req);
        return req ? STALL_ID : STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
// master = stage side, slave = sequencer side.
interface pipe_ctrl_if #(
    parameter int MC_W   = 6,
    parameter int PERF_W = 32
);
    logic              stallreq_id_i;
    logic              ex_mc_start_i;
    logic [MC_W-1:0]   ex_mc_cycles_i;
    logic              flush_req_i;
    logic [31:0]       flush_pc_i;
    logic [5:0]        stall_o;
    logic              flush_o;
    logic [31:0]       new_pc_o;
    logic              mc_last_o;
    logic              ex_busy_o;
    logic [PERF_W-1:0] stall_cnt_o;

    modport master (
        output stallreq_id_i, ex_mc_start_i, ex_mc_cycles_i,
        output flush_req_i, flush_pc_i,
        input  stall_o, flush_o, new_pc_o,
        input  mc_last_o, ex_busy_o, stall_cnt_o
    );

    modport slave (
        input  stallreq_id_i, ex_mc_start_i, ex_mc_cycles_i,
        input  flush_req_i, flush_pc_i,
        output stall_o, flush_o, new_pc_o,
        output mc_last_o, ex_busy_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && !(&q)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage stall vector, multi-cycle EX hold,
// flush/redirect and saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_W   = MC_W_DEF,
    parameter int PERF_W = PERF_W_DEF
) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave bus
);

    pc_state_t       state, state_n;
    logic [MC_W-1:0] cnt, cnt_n;
    logic            mc_go;
    logic            cnt_zero;
    logic [5:0]      stall;

    assign mc_go    = bus.ex_mc_start_i && (bus.ex_mc_cycles_i != '0);
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PC_RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (bus.flush_req_i) begin
            state_n = PC_RUN;
            cnt_n   = '0;
        end else begin
            unique case (state)
                PC_RUN: begin
                    if (mc_go) begin
                        state_n = PC_MC_WAIT;
                        cnt_n   = bus.ex_mc_cycles_i - MC_W'(1);
                    end
                end
                PC_MC_WAIT: begin
                    if (cnt_zero) begin
                        state_n = PC_RUN;
                    end else begin
                        cnt_n = cnt - MC_W'(1);
                    end
                end
            endcase
        end
    end

    // Reset overrides everything; flush beats any hold or start.
    always_comb begin
        stall         = STALL_NONE;
        bus.flush_o   = 1'b0;
        bus.new_pc_o  = '0;
        bus.mc_last_o = 1'b0;
        bus.ex_busy_o = 1'b0;
        if (!rst) begin
            bus.ex_busy_o = (state == PC_MC_WAIT);
            if (bus.flush_req_i) begin
                bus.flush_o  = 1'b1;
                bus.new_pc_o = bus.flush_pc_i;
            end else begin
                unique case (state)
                    PC_RUN: begin
                        if (mc_go) begin
                            stall = STALL_EX;
                        end else begin
                            stall         = id_stall(bus.stallreq_id_i);
                            bus.mc_last_o = bus.ex_mc_start_i;
                        end
                    end
                    PC_MC_WAIT: begin
                        if (cnt_zero) begin
                            stall         = id_stall(bus.stallreq_id_i);
                            bus.mc_last_o = 1'b1;
                        end else begin
                            stall = STALL_EX;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.stall_o = stall;

    sat_counter #(
        .W (PERF_W)
    ) u_perf (
        .clk (clk),
        .clr (rst),
        .en  (stall[0]),
        .q   (bus.stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus random bench for pipe_ctrl against a cycles-left model.
// Narrow perf counter so saturation is reachable quickly.
module tb_pipe_ctrl;

    localparam int MC_W   = 6;
    localparam int PERF_W = 4;
    localparam int PMAX   = (1 << PERF_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.MC_W(MC_W), .PERF_W(PERF_W)) bus ();

    pipe_ctrl #(.MC_W(MC_W), .PERF_W(PERF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int left  = 0;
    int perf  = 0;
    bit perf_known = 0;

    logic [5:0]  e_stall;
    logic        e_flush, e_last, e_busy;
    logic [31:0] e_pc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit id, input bit st,
                         input int n, input bit fl,
                         input logic [31:0] pc);
        rst                = r;
        bus.stallreq_id_i  = id;
        bus.ex_mc_start_i  = st;
        bus.ex_mc_cycles_i = MC_W'(n);
        bus.flush_req_i    = fl;
        bus.flush_pc_i     = pc;
    endtask

    task automatic settle();
        logic [5:0] ids;
        #4;
        ids     = bus.stallreq_id_i ? 6'b000111 : 6'b000000;
        e_stall = 6'b000000;
        e_flush = 1'b0;
        e_pc    = 32'h0;
        e_last  = 1'b0;
        e_busy  = 1'b0;
        if (!rst) begin
            e_busy = (left > 0);
            if (bus.flush_req_i) begin
                e_flush = 1'b1;
                e_pc    = bus.flush_pc_i;
            end else if (left > 1) begin
                e_stall = 6'b001111;
            end else if (left == 1) begin
                e_stall = ids;
                e_last  = 1'b1;
            end else if (bus.ex_mc_start_i) begin
                if (bus.ex_mc_cycles_i != 0) e_stall = 6'b001111;
                else begin
                    e_stall = ids;
                    e_last  = 1'b1;
                end
            end else begin
                e_stall = ids;
            end
        end
        chk("stall", 32'(bus.stall_o), 32'(e_stall));
        chk("flush", 32'(bus.flush_o), 32'(e_flush));
        chk("new_pc", bus.new_pc_o, e_pc);
        chk("mc_last", 32'(bus.mc_last_o), 32'(e_last));
        chk("ex_busy", 32'(bus.ex_busy_o), 32'(e_busy));
        if (perf_known && !rst)
            chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(perf));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            left       = 0;
            perf       = 0;
            perf_known = 1;
        end else begin
            if (e_stall[0] && perf < PMAX) perf++;
            if (bus.flush_req_i) left = 0;
            else if (left > 0) left--;
            else if (bus.ex_mc_start_i) left = int'(bus.ex_mc_cycles_i);
        end
        @(negedge clk);
    endtask

    task automatic cyc(input bit r, input bit id, input bit st,
                       input int n, input bit fl,
                       input logic [31:0] pc);
        drive(r, id, st, n, fl, pc);
        settle();
        advance();
    endtask

    initial begin
        // reset with noisy inputs
        drive(1, 1, 0, 0, 1, 32'hDEAD_BEEF);
        settle();
        chk("rst_stall", 32'(bus.stall_o), 32'h0);
        chk("rst_flush", 32'(bus.flush_o), 32'h0);
        chk("rst_pc", bus.new_pc_o, 32'h0);
        advance();
        cyc(1, 1, 0, 0, 1, 32'hDEAD_BEEF);
        drive(0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("rst_cnt", 32'(bus.stall_cnt_o), 32'h0);
        advance();

        // decode stall for 3 cycles
        repeat (3) begin
            drive(0, 1, 0, 0, 0, 32'h0);
            settle();
            chk("id_stall", 32'(bus.stall_o), 32'h07);
            advance();
        end
        drive(0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("id_stall_end", 32'(bus.stall_o), 32'h00);
        chk("perf3", 32'(bus.stall_cnt_o), 32'd3);
        advance();

        // N=3 multi-cycle
        drive(0, 0, 1, 3, 0, 32'h0);
        settle();
        chk("mc3_T", 32'(bus.stall_o), 32'h0F);
        advance();
        repeat (2) begin
            drive(0, 1, 0, 0, 0, 32'h0);
            settle();
            chk("mc3_hold", 32'(bus.stall_o), 32'h0F);
            chk("mc3_busy", 32'(bus.ex_busy_o), 32'h1);
            advance();
        end
        drive(0, 0, 1, 2, 0, 32'h0);
        settle();
        chk("mc3_last", 32'(bus.mc_last_o), 32'h1);
        chk("mc3_last_st", 32'(bus.stall_o), 32'h00);
        chk("mc3_last_bz", 32'(bus.ex_busy_o), 32'h1);
        advance();
        cyc(0, 0, 0, 0, 0, 32'h0);

        // N=0 and N=1
        drive(0, 1, 1, 0, 0, 32'h0);
        settle();
        chk("mc0_last", 32'(bus.mc_last_o), 32'h1);
        chk("mc0_stall", 32'(bus.stall_o), 32'h07);
        advance();
        drive(0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("mc0_busy", 32'(bus.ex_busy_o), 32'h0);
        advance();
        cyc(0, 0, 1, 1, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("mc1_last", 32'(bus.mc_last_o), 32'h1);
        advance();

        // flush aborts N=5
        cyc(0, 0, 1, 5, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 1, 32'h0000_0100);
        settle();
        chk("fl_flush", 32'(bus.flush_o), 32'h1);
        chk("fl_pc", bus.new_pc_o, 32'h100);
        chk("fl_stall", 32'(bus.stall_o), 32'h00);
        advance();
        repeat (5) begin
            drive(0, 0, 0, 0, 0, 32'h0);
            settle();
            chk("fl_nolast", 32'(bus.mc_last_o), 32'h0);
            chk("fl_nobusy", 32'(bus.ex_busy_o), 32'h0);
            advance();
        end

        // flush beats start and decode stall
        drive(0, 1, 1, 4, 1, 32'h0000_2000);
        settle();
        chk("all_flush", 32'(bus.flush_o), 32'h1);
        chk("all_stall", 32'(bus.stall_o), 32'h00);
        advance();
        drive(0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("all_busy", 32'(bus.ex_busy_o), 32'h0);
        advance();

        // saturation
        repeat (PMAX + 6) cyc(0, 1, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("sat", 32'(bus.stall_cnt_o), 32'(PMAX));
        advance();

        // random phase
        cyc(1, 0, 0, 0, 0, 32'h0);
        repeat (600) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 5)),
                ($urandom_range(0, 15) == 0),
                $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
